// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Multiplexed 7-segment scan controller with frame-aligned value
//            update and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  blank_lz,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  upd_pending
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = $clog2(DIGITS);
    localparam int VW = 4 * DIGITS;

    localparam logic [CW-1:0]     c_CNT_LAST = CW'(DIV - 1);
    localparam logic [PW-1:0]     c_PTR_LAST = PW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] c_AN_RST   = {{(DIGITS-1){1'b1}}, 1'b0};
    localparam logic [DIGITS-1:0] c_ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_ptr;
    logic [VW-1:0]     r_disp;
    logic [VW-1:0]     r_pend;
    logic              r_pend_valid;
    logic [3:0]        r_bcd;
    logic [DIGITS-1:0] r_an;
    logic              r_frame_done;

    logic              w_tick;
    logic              w_wrap;
    logic [PW-1:0]     w_ptr_next;
    logic [VW-1:0]     w_disp_next;
    logic [DIGITS-1:0] w_zero_above;
    logic              w_blank;
    logic [DIGITS-1:0] w_an_next;

    assign w_tick     = (r_cnt == c_CNT_LAST);
    assign w_wrap     = w_tick && (r_ptr == c_PTR_LAST);
    assign w_ptr_next = (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;

    // A load coinciding with the wrap tick bypasses the buffer entirely.
    always_comb begin
        w_disp_next = r_disp;
        if (w_wrap) begin
            if (load) begin
                w_disp_next = value_in;
            end else if (r_pend_valid) begin
                w_disp_next = r_pend;
            end
        end
    end

    // w_zero_above[k] is set when nibbles DIGITS-1 down to k are all zero.
    always_comb begin
        w_zero_above = '0;
        w_zero_above[DIGITS-1] = (w_disp_next[4*(DIGITS-1) +: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            w_zero_above[k] = w_zero_above[k+1] && (w_disp_next[4*k +: 4] == 4'h0);
        end
    end

    assign w_blank   = blank_lz && (w_ptr_next != '0) && w_zero_above[w_ptr_next];
    assign w_an_next = w_blank ? '1 : ~(c_ONE_HOT0 << w_ptr_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_bcd        <= 4'h0;
            r_an         <= c_AN_RST;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
            r_disp       <= w_disp_next;
            r_frame_done <= w_wrap;
            if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend       <= value_in;
                r_pend_valid <= 1'b1;
            end
            if (w_tick) begin
                r_ptr <= w_ptr_next;
                r_bcd <= w_disp_next[4*w_ptr_next +: 4];
                r_an  <= w_an_next;
            end
        end
    end

    assign bcd_out     = r_bcd;
    assign an          = r_an;
    assign frame_done  = r_frame_done;
    assign upd_pending = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Scoreboard bench for seg_scan_ctrl against a time-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int VW     = 4 * DIGITS;
    localparam int FRAME  = DIGITS * DIV;
    localparam int OW     = DIGITS + 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0;
    logic [VW-1:0]     value_in = '0;
    logic              blank_lz = 1'b0;
    logic [3:0]        bcd_out;
    logic [DIGITS-1:0] an;
    logic              frame_done;
    logic              upd_pending;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value_in    (value_in),
        .blank_lz    (blank_lz),
        .bcd_out     (bcd_out),
        .an          (an),
        .frame_done  (frame_done),
        .upd_pending (upd_pending)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    // Model state: edges since reset release, shown value and buffered value.
    int                e = 0;
    logic [VW-1:0]     m_disp = '0;
    logic [VW-1:0]     m_pend = '0;
    bit                m_pv = 1'b0;
    logic [3:0]        x_bcd = 4'h0;
    logic [DIGITS-1:0] x_an = {{(DIGITS-1){1'b1}}, 1'b0};
    bit                x_fd = 1'b0;
    bit                bl_g = 1'b0;

    task automatic cycle(input bit r, input bit ld, input logic [VW-1:0] v, input bit bl);
        int s;
        bit tick, wrap;
        logic [VW-1:0] upper;
        rst = r; load = ld; value_in = v; blank_lz = bl;
        @(posedge clk);
        if (r) begin
            e = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
            x_bcd = 4'h0; x_an = {{(DIGITS-1){1'b1}}, 1'b0}; x_fd = 1'b0;
        end else begin
            e++;
            tick = (e % DIV) == 0;
            wrap = (e % FRAME) == 0;
            if (wrap) begin
                if (ld) m_disp = v;
                else if (m_pv) m_disp = m_pend;
                m_pv = 1'b0;
            end else if (ld) begin
                m_pend = v;
                m_pv = 1'b1;
            end
            x_fd = wrap;
            if (tick) begin
                s = (e / DIV) % DIGITS;
                upper = m_disp >> (4 * s);
                x_bcd = upper[3:0];
                if (bl && s != 0 && upper == '0) x_an = '1;
                else x_an = ~(DIGITS'(1) << s);
            end
        end
        exp_q.push_back({x_an, x_bcd, x_fd, m_pv});
        pushed++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, bl_g);
    endtask

    // Run until the next edge will bring the frame position to m.
    task automatic wait_pos(input int m);
        for (int i = 0; i < FRAME && ((e + 1) % FRAME) != m; i++) cycle(1'b0, 1'b0, '0, bl_g);
    endtask

    always @(negedge clk) begin
        logic [OW-1:0] x;
        logic [OW-1:0] a;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            a = {an, bcd_out, frame_done, upd_pending};
            popped++;
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL outputs t=%0t e=%0d an/bcd/fd/upd got %b/%h/%b/%b need %b/%h/%b/%b",
                         $time, e, a[OW-1 -: DIGITS], a[5:2], a[1], a[0],
                         x[OW-1 -: DIGITS], x[5:2], x[1], x[0]);
            end
        end
    end

    initial begin
        logic [VW-1:0] rv;
        int nz;
        // Reset then scan order.
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 16'h1234, bl_g);
        idle(2 * FRAME);
        // Tear-free update, last load wins.
        wait_pos(5);
        cycle(1'b0, 1'b1, 16'h5678, bl_g);
        idle(FRAME);
        wait_pos(6);
        cycle(1'b0, 1'b1, 16'h5678, bl_g);
        idle(3);
        cycle(1'b0, 1'b1, 16'h9ABC, bl_g);
        idle(FRAME + 4);
        // Leading-zero blanking.
        bl_g = 1'b1;
        cycle(1'b0, 1'b1, 16'h0050, bl_g);
        idle(2 * FRAME);
        cycle(1'b0, 1'b1, 16'h0000, bl_g);
        idle(2 * FRAME);
        bl_g = 1'b0;
        idle(FRAME);
        // Load in the wrap-tick cycle discards the older buffered value.
        cycle(1'b0, 1'b1, 16'h1111, bl_g);
        wait_pos(0);
        cycle(1'b0, 1'b1, 16'h9999, bl_g);
        idle(FRAME);
        // Reset mid-frame with an update pending.
        wait_pos(9);
        cycle(1'b0, 1'b1, 16'h4321, bl_g);
        cycle(1'b1, 1'b0, '0, bl_g);
        idle(2 * FRAME);
        // Randomized traffic with sparse loads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            nz = $urandom_range(DIGITS, 0);
            rv = VW'($urandom) & ((VW'(1) << (4 * nz)) - 1'b1);
            if (nz == DIGITS) rv = VW'($urandom);
            if ($urandom_range(63, 0) == 0) bl_g = ~bl_g;
            cycle($urandom_range(299, 0) == 0, $urandom_range(9, 0) == 0, rv, bl_g);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL drain popped %0d need %0d", popped, pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share a single BCD-to-7-segment decoder. It holds a packed multi-digit BCD value and steps a digit pointer at a divided rate. For each digit it presents the selected nibble to the decoder and drives an active-low digit enable. New values are buffered and applied only at frame boundaries, so the display never tears. Optional leading-zero blanking is supported.

## Interface
- DIGITS, 4: number of digits scanned (2..8).
- DIV, 50000: clk cycles per digit slot; minimum 1, where 1 gives one slot per cycle.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle request to display value_in.
- value_in  in  4*DIGITS  packed BCD value; nibble i = digit i; digit 0 is the least significant, rightmost digit.
- blank_lz  in  1  1 = blank leading zero digits.
- bcd_out  out  4  nibble of the current digit; goes to the decoder input.
- an  out  DIGITS  active-low digit enables; at most one bit is low.
- frame_done  out  1  one-cycle pulse when a new frame starts at digit 0.
- upd_pending  out  1  a loaded value is waiting for the frame boundary.

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps to 0. tick is asserted when cnt==DIV-1.
- Digit pointer ptr advances on each tick: 0,1,…,DIGITS-1,0. The tick that moves ptr from DIGITS-1 to 0 is the wrap tick.
- Registers:
  - disp: the displayed value.
  - pend: the buffered value.
  - pend_valid: drives upd_pending.
- load on a non-wrap-tick cycle: pend<=value_in and pend_valid<=1. A later load before the boundary overwrites pend (last load wins).
- Wrap tick without load: if pend_valid, then disp<=pend and pend_valid<=0.
- Wrap tick with simultaneous load: disp<=value_in directly and pend_valid<=0. Any older pend is discarded.
- Per slot, outputs are computed from disp as updated on this edge and from the new ptr:
  - bcd_out = disp nibble[ptr].
  - an = all ones, except bit ptr = 0.
- Leading-zero blanking:
  - Applies when blank_lz=1 at the tick edge.
  - A digit k ≥ 1 is blanked if nibbles DIGITS-1 down to k are all 0.
  - A blanked slot forces an to all ones; bcd_out still carries the nibble.
  - Digit 0 is never blanked.
- Nibbles A–F are passed through unchanged (the decoder shows hex); no range checking.
- frame_done = 1 for exactly the cycle following the wrap tick.
- Reset values:
  - cnt=0, ptr=0, disp=0, pend=0, pend_valid=0.
  - bcd_out=4'h0, an = all ones except bit0=0, frame_done=0, upd_pending=0.
- Reset mid-frame discards pend and returns all state to the reset values. rst has priority over load and tick.

## Timing
- All outputs are registered; combinational paths from inputs to outputs are not allowed.
- bcd_out, an and ptr change on the same edge that consumes a tick. Each slot lasts exactly DIV cycles. One frame lasts DIGITS*DIV cycles.
- upd_pending rises on the edge after a non-wrap load. It falls on the edge that consumes the wrap tick, the same edge on which digit 0 shows the new value.
- Load-to-display latency: at most DIGITS*DIV cycles, at least 1 cycle (load during the wrap tick).
- blank_lz changes take effect at the next slot edge, not mid-slot.
- After reset release, the first tick occurs DIV cycles later. Digit 0 is shown for slot 0 immediately after reset.

## Test plan
- Reset: hold rst for 3 cycles with DIGITS=4, DIV=4 -> an=4'b1110, bcd_out=0, frame_done=0, upd_pending=0. These values hold until cycle 4 after release, then an=4'b1101.
- Scan order: load 16'h1234 during frame 0. From the next frame, (an,bcd_out) = (1110,4), (1101,3), (1011,2), (0111,1), each held 4 cycles, with frame_done pulsing every 16 cycles.
- Tear-free update: with 16'h1234 shown, load 16'h5678 while ptr=1 -> upd_pending=1; slots 2 and 3 still show 2 and 1. At the wrap, digit 0 shows 8 and upd_pending=0. A second load of 16'h9ABC before the wrap results in C,B,A,9 instead.
- Leading-zero blanking: blank_lz=1 with 16'h0050 -> slots 3 and 2 give an=1111; slot 1 gives an=1101 with bcd_out=5; slot 0 gives an=1110 with bcd_out=0. With 16'h0000, only slot 0 is lit. With blank_lz=0, all four slots are lit.
- Simultaneous load and wrap: pend holds 16'h1111 and load 16'h9999 is asserted in the wrap-tick cycle -> digit 0 immediately shows 9, upd_pending stays 0, and 1111 is never displayed.
- Reset mid-operation: assert rst at ptr=2 with upd_pending=1 -> next cycle shows reset values. The subsequent frame shows 0000 and upd_pending stays 0.
